// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the write-master FSM state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_INCR4  = 3'b011
    } hburst_e;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LAST_DATA,
        ST_ERR2
    } wm_state_e;

    // NONSEQ and SEQ both carry a real transfer; they share htrans[1].
    function automatic logic htrans_active(input logic [1:0] t);
        return t[1];
    endfunction

endpackage

// File: rtl/ahb_wdata_hold.sv
// One-entry write-data hold register with valid/ready on the input side.
// A pop and a push on the same edge refill the entry, so the beat stream
// can run back-to-back. While drop is high, accepted data is discarded.
module ahb_wdata_hold (
    input  logic       hclk,
    input  logic       hreset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       fetch_en,
    input  logic       drop,
    input  logic       pop,
    output logic       full,
    output logic       full_nxt,
    output logic [7:0] data
);

    logic push;

    assign in_ready = fetch_en && (!full || pop);
    assign push     = in_valid && in_ready;
    assign full_nxt = (push && !drop) || (full && !pop);

    // Entry storage: a kept push overrides a simultaneous pop.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (push && !drop) begin
            full <= 1'b1;
            data <= in_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ahb_write_master.sv
// AHB-Lite byte-write initiator: single or short INCR/INCR4 bursts, with
// BUSY on data starvation, hready wait states and ERROR abort plus drain.
module ahb_write_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 2
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [7:0]        hwdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              done,
    output logic              err
);

    wm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [LEN_W-1:0]  last_q, last_d;
    logic [LEN_W-1:0]  k_q, k_d;
    logic [LEN_W:0]    fetch_left_q;
    logic              dp_q, dp_d;
    logic              aborted_q, aborted_d;
    logic              armed_q;

    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [7:0]        hwdata_q, hwdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              hold_full, hold_full_nxt, hold_pop, fetch_en;
    logic [7:0]        hold_data;
    logic              cmd_fire, wr_push, addr_fire, abort_now;

    assign cmd_ready = armed_q && (state_q == ST_IDLE) && !done_q && !aborted_q;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_push   = wr_valid && wr_ready;
    assign fetch_en  = (fetch_left_q != '0);
    assign addr_fire = (state_q == ST_ADDR) && hready && htrans_active(htrans_q);
    assign hold_pop  = addr_fire || (aborted_q && hold_full);
    assign abort_now = dp_q && !hready && (hresp == HRESP_ERROR) &&
                       ((state_q == ST_ADDR) || (state_q == ST_LAST_DATA));

    ahb_wdata_hold u_hold (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .in_valid (wr_valid),
        .in_ready (wr_ready),
        .in_data  (wr_data),
        .fetch_en (fetch_en),
        .drop     (aborted_q),
        .pop      (hold_pop),
        .full     (hold_full),
        .full_nxt (hold_full_nxt),
        .data     (hold_data)
    );

    // Next-state and next-output decode; outputs are registered below, so
    // the transfer type for the next cycle looks at next-cycle hold occupancy.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        last_d    = last_q;
        k_d       = k_q;
        dp_d      = dp_q;
        aborted_d = aborted_q;
        htrans_d  = htrans_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hburst_d  = hburst_q;
        hwdata_d  = hwdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        if (aborted_q && !fetch_en && !hold_full) begin
            aborted_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    start_d  = cmd_addr;
                    last_d   = cmd_len;
                    k_d      = '0;
                    haddr_d  = cmd_addr;
                    htrans_d = HTRANS_IDLE;
                    hwrite_d = 1'b0;
                    if (cmd_len == '0) begin
                        hburst_d = HBURST_SINGLE;
                    end else if (({1'b0, cmd_len} == (LEN_W+1)'(3)) &&
                                 (cmd_addr[1:0] == 2'b00)) begin
                        hburst_d = HBURST_INCR4;
                    end else begin
                        hburst_d = HBURST_INCR;
                    end
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (abort_now) begin
                    htrans_d  = HTRANS_IDLE;
                    hwrite_d  = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = ST_ERR2;
                end else if (hready) begin
                    dp_d = htrans_active(htrans_q);
                    if (htrans_active(htrans_q)) begin
                        hwdata_d = hold_data;
                        if (k_q == last_q) begin
                            htrans_d = HTRANS_IDLE;
                            hwrite_d = 1'b0;
                            state_d  = ST_LAST_DATA;
                        end else begin
                            k_d      = k_q + LEN_W'(1);
                            haddr_d  = start_q + ADDR_W'(k_d);
                            htrans_d = hold_full_nxt ? HTRANS_SEQ : HTRANS_BUSY;
                            hwrite_d = 1'b1;
                        end
                    end else begin
                        haddr_d = start_q + ADDR_W'(k_q);
                        if (k_q == '0) begin
                            htrans_d = hold_full_nxt ? HTRANS_NONSEQ : HTRANS_IDLE;
                        end else begin
                            htrans_d = hold_full_nxt ? HTRANS_SEQ : HTRANS_BUSY;
                        end
                        hwrite_d = (htrans_d != HTRANS_IDLE);
                    end
                end
            end

            ST_LAST_DATA: begin
                if (abort_now) begin
                    aborted_d = 1'b1;
                    state_d   = ST_ERR2;
                end else if (hready) begin
                    done_d  = 1'b1;
                    err_d   = (hresp == HRESP_ERROR);
                    dp_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_ERR2: begin
                if (hready) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    dp_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered AHB/status outputs.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q   <= ST_IDLE;
            start_q   <= '0;
            last_q    <= '0;
            k_q       <= '0;
            dp_q      <= 1'b0;
            aborted_q <= 1'b0;
            armed_q   <= 1'b0;
            htrans_q  <= HTRANS_IDLE;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hburst_q  <= HBURST_SINGLE;
            hwdata_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            last_q    <= last_d;
            k_q       <= k_d;
            dp_q      <= dp_d;
            aborted_q <= aborted_d;
            armed_q   <= 1'b1;
            htrans_q  <= htrans_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hburst_q  <= hburst_d;
            hwdata_q  <= hwdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Beats still to be taken from the write stream, including drained ones.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            fetch_left_q <= '0;
        end else if (cmd_fire) begin
            fetch_left_q <= {1'b0, cmd_len} + (LEN_W+1)'(1);
        end else if (wr_push) begin
            fetch_left_q <= fetch_left_q - (LEN_W+1)'(1);
        end
    end

    assign htrans = htrans_q;
    assign haddr  = haddr_q;
    assign hwrite = hwrite_q;
    assign hsize  = HSIZE_BYTE;
    assign hburst = hburst_q;
    assign hwdata = hwdata_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_ahb_write_master.sv
// Directed bench for ahb_write_master: single, INCR4, wait states,
// starvation, ERROR abort with drain, mid-burst reset and address wrap.
module tb_ahb_write_master;

    logic        hclk;
    logic        hreset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [7:0]  hwdata;
    logic        hready;
    logic        hresp;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    ahb_write_master #(.ADDR_W(32), .LEN_W(2)) dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hready    (hready),
        .hresp     (hresp),
        .done      (done),
        .err       (err)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [1:0] t, input logic [31:0] a);
        chk({tag, ".htrans"}, 32'(htrans), 32'(t));
        chk({tag, ".haddr"}, haddr, a);
    endtask

    initial begin
        hreset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        hready    = 1'b1;
        hresp     = 1'b0;
        #1;
        chk("rst.htrans", 32'(htrans), 32'h0);
        chk("rst.haddr", haddr, 32'h0);
        chk("rst.hwrite", 32'(hwrite), 32'h0);
        chk("rst.hburst", 32'(hburst), 32'h0);
        chk("rst.hsize", 32'(hsize), 32'h0);
        chk("rst.hwdata", 32'(hwdata), 32'h0);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst.wr_ready", 32'(wr_ready), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        #11 hreset_n = 1'b1;
        step();
        chk("post_rst.cmd_ready", 32'(cmd_ready), 32'h1);

        // Single write, zero wait.
        cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_len = 2'd0;
        wr_valid = 1'b1; wr_data = 8'hA5;
        step();
        cmd_valid = 1'b0;
        chk("s1.idle", 32'(htrans), 32'h0);
        chk("s1.cmd_ready_busy", 32'(cmd_ready), 32'h0);
        chk("s1.wr_ready", 32'(wr_ready), 32'h1);
        step();
        wr_valid = 1'b0;
        chk_bus("s1.nonseq", 2'b10, 32'h10);
        chk("s1.hburst", 32'(hburst), 32'h0);
        chk("s1.hwrite", 32'(hwrite), 32'h1);
        step();
        chk("s1.idle_after", 32'(htrans), 32'h0);
        chk("s1.hwdata", 32'(hwdata), 32'hA5);
        chk("s1.done_early", 32'(done), 32'h0);
        step();
        chk("s1.done", 32'(done), 32'h1);
        chk("s1.err", 32'(err), 32'h0);
        chk("s1.cmd_ready_with_done", 32'(cmd_ready), 32'h0);
        step();
        chk("s1.done_pulse", 32'(done), 32'h0);
        chk("s1.cmd_ready_again", 32'(cmd_ready), 32'h1);

        // INCR4 aligned, streaming data.
        cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_len = 2'd3;
        wr_valid = 1'b1; wr_data = 8'h11;
        step();
        cmd_valid = 1'b0;
        chk("b4.idle", 32'(htrans), 32'h0);
        step();
        chk_bus("b4.beat0", 2'b10, 32'h20);
        chk("b4.hburst", 32'(hburst), 32'h3);
        wr_data = 8'h22;
        chk("b4.wr_ready_refill", 32'(wr_ready), 32'h1);
        step();
        chk_bus("b4.beat1", 2'b11, 32'h21);
        chk("b4.hwdata0", 32'(hwdata), 32'h11);
        wr_data = 8'h33;
        step();
        chk_bus("b4.beat2", 2'b11, 32'h22);
        chk("b4.hwdata1", 32'(hwdata), 32'h22);
        wr_data = 8'h44;
        step();
        chk_bus("b4.beat3", 2'b11, 32'h23);
        chk("b4.hwdata2", 32'(hwdata), 32'h33);
        wr_valid = 1'b0;
        step();
        chk("b4.idle_after", 32'(htrans), 32'h0);
        chk("b4.hwdata3", 32'(hwdata), 32'h44);
        chk("b4.done_early", 32'(done), 32'h0);
        step();
        chk("b4.done", 32'(done), 32'h1);
        chk("b4.err", 32'(err), 32'h0);
        step();
        chk("b4.cmd_ready", 32'(cmd_ready), 32'h1);

        // Same burst, two wait states in beat 1's data phase.
        cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_len = 2'd3;
        wr_valid = 1'b1; wr_data = 8'h11;
        step();
        cmd_valid = 1'b0;
        step();
        chk_bus("ws.beat0", 2'b10, 32'h20);
        wr_data = 8'h22;
        step();
        chk_bus("ws.beat1", 2'b11, 32'h21);
        wr_data = 8'h33;
        step();
        hready = 1'b0;
        wr_data = 8'h44;
        #1;
        chk_bus("ws.hold0", 2'b11, 32'h22);
        chk("ws.hold0.hwdata", 32'(hwdata), 32'h22);
        chk("ws.wr_ready_stall", 32'(wr_ready), 32'h0);
        step();
        chk_bus("ws.hold1", 2'b11, 32'h22);
        chk("ws.hold1.hwdata", 32'(hwdata), 32'h22);
        step();
        hready = 1'b1;
        chk_bus("ws.hold2", 2'b11, 32'h22);
        chk("ws.hold2.hwdata", 32'(hwdata), 32'h22);
        step();
        chk_bus("ws.beat3", 2'b11, 32'h23);
        chk("ws.hwdata2", 32'(hwdata), 32'h33);
        wr_valid = 1'b0;
        step();
        chk("ws.hwdata3", 32'(hwdata), 32'h44);
        step();
        chk("ws.done", 32'(done), 32'h1);
        chk("ws.err", 32'(err), 32'h0);
        step();

        // Starvation before beat 1 of a 2-beat INCR.
        cmd_valid = 1'b1; cmd_addr = 32'h41; cmd_len = 2'd1;
        wr_valid = 1'b1; wr_data = 8'hB0;
        step();
        cmd_valid = 1'b0;
        step();
        chk_bus("st.beat0", 2'b10, 32'h41);
        chk("st.hburst", 32'(hburst), 32'h1);
        wr_valid = 1'b0;
        step();
        chk_bus("st.busy0", 2'b01, 32'h42);
        chk("st.busy0.hwrite", 32'(hwrite), 32'h1);
        chk("st.hwdata0", 32'(hwdata), 32'hB0);
        step();
        chk_bus("st.busy1", 2'b01, 32'h42);
        step();
        chk_bus("st.busy2", 2'b01, 32'h42);
        wr_valid = 1'b1; wr_data = 8'hB1;
        step();
        chk_bus("st.beat1", 2'b11, 32'h42);
        wr_valid = 1'b0;
        step();
        chk("st.hwdata1", 32'(hwdata), 32'hB1);
        step();
        chk("st.done", 32'(done), 32'h1);
        chk("st.err", 32'(err), 32'h0);
        step();

        // ERROR on beat 0 of a 4-beat burst, remaining beats drained.
        cmd_valid = 1'b1; cmd_addr = 32'h30; cmd_len = 2'd3;
        wr_valid = 1'b1; wr_data = 8'hD0;
        step();
        cmd_valid = 1'b0;
        step();
        chk_bus("er.beat0", 2'b10, 32'h30);
        wr_data = 8'hD1;
        step();
        chk_bus("er.beat1", 2'b11, 32'h31);
        hresp = 1'b1; hready = 1'b0; wr_data = 8'hD2;
        step();
        chk("er.cancel", 32'(htrans), 32'h0);
        chk("er.hwrite", 32'(hwrite), 32'h0);
        hready = 1'b1;
        #1;
        chk("er.drain_ready0", 32'(wr_ready), 32'h1);
        chk("er.cmd_blocked0", 32'(cmd_ready), 32'h0);
        step();
        chk("er.done", 32'(done), 32'h1);
        chk("er.err", 32'(err), 32'h1);
        chk("er.no_seq0", 32'(htrans), 32'h0);
        chk("er.cmd_blocked1", 32'(cmd_ready), 32'h0);
        hresp = 1'b0; wr_data = 8'hD3;
        #1;
        chk("er.drain_ready1", 32'(wr_ready), 32'h1);
        step();
        chk("er.done_pulse", 32'(done), 32'h0);
        chk("er.no_seq1", 32'(htrans), 32'h0);
        chk("er.drain_end", 32'(wr_ready), 32'h0);
        chk("er.cmd_blocked2", 32'(cmd_ready), 32'h0);
        wr_valid = 1'b0;
        step();
        chk("er.cmd_ready", 32'(cmd_ready), 32'h1);
        chk("er.no_seq2", 32'(htrans), 32'h0);

        // Reset in the middle of a burst.
        cmd_valid = 1'b1; cmd_addr = 32'h50; cmd_len = 2'd3;
        wr_valid = 1'b1; wr_data = 8'hE0;
        step();
        cmd_valid = 1'b0;
        step();
        wr_data = 8'hE1;
        step();
        wr_data = 8'hE2;
        step();
        chk_bus("rm.beat2", 2'b11, 32'h52);
        wr_valid = 1'b0;
        #2 hreset_n = 1'b0;
        #1;
        chk("rm.htrans", 32'(htrans), 32'h0);
        chk("rm.haddr", haddr, 32'h0);
        chk("rm.hwdata", 32'(hwdata), 32'h0);
        chk("rm.hburst", 32'(hburst), 32'h0);
        chk("rm.hwrite", 32'(hwrite), 32'h0);
        chk("rm.wr_ready", 32'(wr_ready), 32'h0);
        chk("rm.cmd_ready", 32'(cmd_ready), 32'h0);
        step();
        chk("rm.done_in_rst", 32'(done), 32'h0);
        #3 hreset_n = 1'b1;
        step();
        chk("rm.done_after", 32'(done), 32'h0);
        chk("rm.cmd_ready", 32'(cmd_ready), 32'h1);

        // Fresh command after reset, crossing the top of the address space.
        cmd_valid = 1'b1; cmd_addr = 32'hFFFF_FFFF; cmd_len = 2'd1;
        wr_valid = 1'b1; wr_data = 8'h5A;
        step();
        cmd_valid = 1'b0;
        chk("wr.idle", 32'(htrans), 32'h0);
        step();
        chk_bus("wr.beat0", 2'b10, 32'hFFFF_FFFF);
        chk("wr.hburst", 32'(hburst), 32'h1);
        wr_data = 8'h5B;
        step();
        chk_bus("wr.beat1", 2'b11, 32'h0000_0000);
        chk("wr.hwdata0", 32'(hwdata), 32'h5A);
        wr_valid = 1'b0;
        step();
        chk("wr.hwdata1", 32'(hwdata), 32'h5B);
        step();
        chk("wr.done", 32'(done), 32'h1);
        chk("wr.err", 32'(err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_write_master.md
Name: ahb_write_master

Overview:
- AHB-Lite initiator that issues byte-wide write transfers (single or short incrementing burst) to AHB write responders such as the payload/size register slave.
- Accepts a command (address, beat count) plus a per-beat write-data stream from local control logic.
- Drives pipelined address/data phases, honours hready wait states, inserts BUSY on data starvation and aborts a burst on an ERROR response.
- Reports completion and error status.

Parameters:
- ADDR_W, 32, haddr/cmd_addr width.
- LEN_W, 2, cmd_len width; beats = cmd_len+1, so 1..4 beats.

Ports:
- hclk  in  1  clock
- hreset_n  in  1  async active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_addr  in  ADDR_W  start byte address
- cmd_len  in  LEN_W  beats minus one
- wr_valid  in  1  beat data valid
- wr_ready  out  1  beat data accepted when valid&ready
- wr_data  in  8  beat data
- haddr  out  ADDR_W  AHB address
- htrans  out  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  out  1  always 1 during non-IDLE
- hsize  out  3  fixed 000 (byte)
- hburst  out  3  SINGLE=000, INCR=001, INCR4=011
- hwdata  out  8  write data
- hready  in  1  transfer ready from interconnect
- hresp  in  1  0=OKAY, 1=ERROR
- done  out  1  one-cycle pulse at command completion
- err  out  1  valid with done; 1 when any beat got ERROR

Behaviour:
- Reset (hreset_n low, async): htrans=IDLE, haddr=0, hwrite=0, hburst=0, hsize=0, hwdata=0, cmd_ready=0, wr_ready=0, done=0, err=0, FSM=IDLE, hold register empty.
- All AHB outputs are registered. A reset mid-burst abandons it with no done pulse.
- Hold register: one 8-bit entry. wr_ready = entry empty and beats remain to be fetched for the active command.
- FSM states: IDLE, ADDR, LAST_DATA, ERR2.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake, latch addr and beats_left = cmd_len+1.
  - hburst = SINGLE if len 1; INCR4 if len 4 and cmd_addr[1:0]==0; otherwise INCR.
  - Go to ADDR.
- ADDR (address phase of beat k):
  - Issue beat k only when the hold register is full: htrans=NONSEQ for k=0, SEQ otherwise, haddr = start+k.
  - If the hold register is empty: k=0 drives IDLE; k>0 drives BUSY with haddr = start+k, same hburst.
  - The address phase completes on the edge where hready=1 and htrans is NONSEQ/SEQ. On that edge:
    - hwdata <= hold register; hold register empties.
    - If this was the last beat, go to LAST_DATA with htrans=IDLE.
    - Otherwise advance k.
  - While hready=0, all AHB outputs hold, including BUSY.
- LAST_DATA: wait for hready=1 with hresp=0, then pulse done with err=0 and return to IDLE.
- hwdata holds its value until the data phase completes, i.e. the edge where hready=1.
- ERROR handling:
  - In any data phase, sampling hresp=1 with hready=0 (first ERROR cycle) drives htrans=IDLE on the next cycle, cancelling any pending SEQ, and moves to ERR2.
  - ERR2 waits for hready=1, pulses done with err=1 and returns to IDLE.
  - Remaining beats' data is drained: wr_ready stays 1 and data is discarded until the beat count is consumed. cmd_ready stays 0 until the drain finishes.
- Simultaneous events:
  - An address phase can complete on the same edge as the previous data phase completes; these overlap normally.
  - A wr handshake and a hold-register empty on the same edge refill the register.
- haddr wraps modulo 2^ADDR_W.
- done is never asserted in the same cycle as cmd_ready=1.

Decomposition:
- Shared package ahb_pkg: htrans, hburst and hsize encodings, hresp OKAY/ERROR constants, FSM state enum.
- One natural sub-module: ahb_wdata_hold, the 1-entry hold register with valid/ready handshake.

Test Plan:
- Single write, zero wait: cmd addr=0x10, len=0, data 0xA5 ready.
  - Expect: NONSEQ haddr=0x10 hburst=000 for 1 cycle, then hwdata=0xA5.
  - done=1, err=0 two cycles after address phase.
- INCR4 aligned: addr=0x20, len=3, data 11,22,33,44 streaming.
  - Expect: NONSEQ 0x20, then SEQ 0x21..0x23, hburst=011.
  - hwdata 11..44 each one cycle after its address; single done.
- Wait states: same burst with hready=0 for 2 cycles during beat 1's data phase.
  - Expect: haddr=0x22/SEQ and hwdata=22 held stable for 3 cycles.
- Starvation: len=1 at addr=0x41, wr_valid low 3 cycles before beat 1.
  - Expect: hburst=001, BUSY with haddr=0x42 for 3 cycles, then SEQ 0x42.
- ERROR on beat 0 of a len=3 burst: hresp=1/hready=0, then hresp=1/hready=1.
  - Expect: htrans=IDLE in the second cycle; no further SEQ.
  - 3 remaining data beats drained; done=1, err=1.
- Reset asserted mid-burst after beat 1.
  - Expect: outputs immediately at reset values, no done pulse.
  - Next command starts cleanly with NONSEQ.
